// File: rtl/ibex_pmp_csr_pkg.sv
// Shared PMP CSR definitions: CSR addresses, cfg/mseccfg layouts and helpers.
package ibex_pmp_csr_pkg;

  localparam int unsigned PMP_CFG_W = 8;
  localparam int unsigned PMP_MAX_REGIONS = 16;

  localparam logic [11:0] CSR_PMPCFG0   = 12'h3A0;
  localparam logic [11:0] CSR_PMPCFG1   = 12'h3A1;
  localparam logic [11:0] CSR_PMPCFG2   = 12'h3A2;
  localparam logic [11:0] CSR_PMPCFG3   = 12'h3A3;
  localparam logic [11:0] CSR_PMPADDR0  = 12'h3B0;
  localparam logic [11:0] CSR_PMPADDR1  = 12'h3B1;
  localparam logic [11:0] CSR_PMPADDR2  = 12'h3B2;
  localparam logic [11:0] CSR_PMPADDR3  = 12'h3B3;
  localparam logic [11:0] CSR_PMPADDR4  = 12'h3B4;
  localparam logic [11:0] CSR_PMPADDR5  = 12'h3B5;
  localparam logic [11:0] CSR_PMPADDR6  = 12'h3B6;
  localparam logic [11:0] CSR_PMPADDR7  = 12'h3B7;
  localparam logic [11:0] CSR_PMPADDR8  = 12'h3B8;
  localparam logic [11:0] CSR_PMPADDR9  = 12'h3B9;
  localparam logic [11:0] CSR_PMPADDR10 = 12'h3BA;
  localparam logic [11:0] CSR_PMPADDR11 = 12'h3BB;
  localparam logic [11:0] CSR_PMPADDR12 = 12'h3BC;
  localparam logic [11:0] CSR_PMPADDR13 = 12'h3BD;
  localparam logic [11:0] CSR_PMPADDR14 = 12'h3BE;
  localparam logic [11:0] CSR_PMPADDR15 = 12'h3BF;
  localparam logic [11:0] CSR_MSECCFG   = 12'h747;
  localparam logic [11:0] CSR_MSECCFGH  = 12'h757;

  typedef enum logic [1:0] {
    PMP_MODE_OFF   = 2'b00,
    PMP_MODE_TOR   = 2'b01,
    PMP_MODE_NA4   = 2'b10,
    PMP_MODE_NAPOT = 2'b11
  } pmp_cfg_mode_e;

  typedef struct packed {
    logic          lock;
    pmp_cfg_mode_e mode;
    logic          exec;
    logic          write;
    logic          read;
  } pmp_cfg_t;

  typedef struct packed {
    logic rlb;
    logic mmwp;
    logic mml;
  } pmp_mseccfg_t;

  // Architectural byte layout of one pmpcfg entry: {L, 00, A, X, W, R}.
  function automatic logic [PMP_CFG_W-1:0] pmp_cfg_pack(input pmp_cfg_t cfg);
    return {cfg.lock, 2'b00, cfg.mode, cfg.exec, cfg.write, cfg.read};
  endfunction

endpackage

// File: rtl/ibex_pmp_csr_entry.sv
// One PMP region: cfg and address flops, lock checks and WARL legalisation.
module ibex_pmp_csr_entry
  import ibex_pmp_csr_pkg::*;
#(
  parameter int unsigned PMPGranularity = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_we,
  input  logic [5:0]  cfg_wdata,
  input  logic        addr_we,
  input  logic [31:0] addr_wdata,
  input  logic        next_lock,
  input  logic        next_tor,
  input  logic        mml,
  input  logic        rlb,
  output pmp_cfg_t    cfg,
  output logic [31:0] addr,
  output logic [7:0]  cfg_rdata,
  output logic [31:0] addr_rdata,
  output logic        ignored
);

  // Low address bits that read as 1 in NAPOT and as 0 in OFF/TOR.
  localparam logic [31:0] NapotOnes = (PMPGranularity >= 2) ?
      ((32'd1 << (PMPGranularity - 1)) - 32'd1) : 32'd0;
  localparam logic [31:0] TorZeros = (PMPGranularity >= 1) ?
      ((32'd1 << PMPGranularity) - 32'd1) : 32'd0;

  pmp_cfg_t    cfg_q;
  pmp_cfg_t    cfg_d;
  logic [31:0] addr_q;
  logic        locked;
  logic        mml_block;
  logic        cfg_ok;
  logic        addr_ok;

  // Legalise incoming cfg byte: drop W without R unless MML, drop NA4 when coarser than 4 bytes.
  always_comb begin
    cfg_d.lock  = cfg_wdata[5];
    cfg_d.mode  = pmp_cfg_mode_e'(cfg_wdata[4:3]);
    cfg_d.exec  = cfg_wdata[2];
    cfg_d.write = cfg_wdata[1] & (cfg_wdata[0] | mml);
    cfg_d.read  = cfg_wdata[0];
    if ((PMPGranularity >= 1) && (cfg_d.mode == PMP_MODE_NA4)) begin
      cfg_d.mode = PMP_MODE_OFF;
    end
  end

  // Lock decisions use only stored state, never the data being written.
  always_comb begin
    locked    = cfg_q.lock & ~rlb;
    mml_block = mml & ~rlb & cfg_wdata[5] &
                (cfg_wdata[2] | (~cfg_wdata[0] & cfg_wdata[1]));
    cfg_ok    = cfg_we & ~locked & ~mml_block;
    addr_ok   = addr_we & ~locked & ~(next_lock & ~rlb & next_tor);
    ignored   = (cfg_we & ~cfg_ok) | (addr_we & ~addr_ok);
  end

  // Region state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q  <= '0;
      addr_q <= '0;
    end else begin
      if (cfg_ok) begin
        cfg_q <= cfg_d;
      end
      if (addr_ok) begin
        addr_q <= addr_wdata;
      end
    end
  end

  // Granularity-dependent address readback; stored bits are left untouched.
  always_comb begin
    addr_rdata = addr_q;
    if (cfg_q.mode == PMP_MODE_NAPOT) begin
      addr_rdata = addr_q | NapotOnes;
    end else if ((cfg_q.mode == PMP_MODE_OFF) || (cfg_q.mode == PMP_MODE_TOR)) begin
      addr_rdata = addr_q & ~TorZeros;
    end
  end

  assign cfg       = cfg_q;
  assign addr      = addr_q;
  assign cfg_rdata = pmp_cfg_pack(cfg_q);

endmodule

// File: rtl/ibex_pmp_csr.sv
// PMP CSR storage: decodes pmpcfg/pmpaddr/mseccfg writes and feeds the PMP checker.
module ibex_pmp_csr
  import ibex_pmp_csr_pkg::*;
#(
  parameter int unsigned PMPGranularity = 0,
  parameter int unsigned PMPNumRegions  = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         csr_we_i,
  input  logic [11:0]  csr_addr_i,
  input  logic [31:0]  csr_wdata_i,
  output logic [31:0]  csr_rdata_o,
  output logic         csr_hit_o,
  output logic         csr_wr_ignored_o,
  output pmp_cfg_t     csr_pmp_cfg_o     [PMPNumRegions],
  output logic [33:0]  csr_pmp_addr_o    [PMPNumRegions],
  output pmp_mseccfg_t csr_pmp_mseccfg_o
);

  pmp_mseccfg_t             mseccfg_q;
  pmp_cfg_t                 cfg_q      [PMPNumRegions];
  logic [31:0]              addr_q     [PMPNumRegions];
  logic [7:0]               cfg_rdata  [PMPNumRegions];
  logic [31:0]              addr_rdata [PMPNumRegions];
  logic [PMPNumRegions-1:0] entry_lock;
  logic [PMPNumRegions-1:0] entry_ignored;
  logic                     mseccfg_we;
  logic                     rlb_writable;
  logic                     rlb_ignored;

  // Address decode: pmpcfg0-3, pmpaddr0-15, mseccfg and mseccfgh.
  always_comb begin
    csr_hit_o = (csr_addr_i[11:2] == CSR_PMPCFG0[11:2]) ||
                (csr_addr_i[11:4] == CSR_PMPADDR0[11:4]) ||
                (csr_addr_i == CSR_MSECCFG) ||
                (csr_addr_i == CSR_MSECCFGH);
  end

  for (genvar g = 0; g < PMPNumRegions; g++) begin : gen_entry
    localparam logic [11:0] CfgAddr  = CSR_PMPCFG0 + 12'(g / 4);
    localparam logic [11:0] AddrAddr = CSR_PMPADDR0 + 12'(g);

    logic next_lock;
    logic next_tor;

    if (g + 1 < PMPNumRegions) begin : gen_next
      assign next_lock = cfg_q[g+1].lock;
      assign next_tor  = (cfg_q[g+1].mode == PMP_MODE_TOR);
    end else begin : gen_last
      assign next_lock = 1'b0;
      assign next_tor  = 1'b0;
    end

    ibex_pmp_csr_entry #(
      .PMPGranularity(PMPGranularity)
    ) u_entry (
      .clk       (clk_i),
      .rst_n     (rst_ni),
      .cfg_we    (csr_we_i && (csr_addr_i == CfgAddr)),
      .cfg_wdata ({csr_wdata_i[8*(g%4)+7], csr_wdata_i[8*(g%4)+:5]}),
      .addr_we   (csr_we_i && (csr_addr_i == AddrAddr)),
      .addr_wdata(csr_wdata_i),
      .next_lock (next_lock),
      .next_tor  (next_tor),
      .mml       (mseccfg_q.mml),
      .rlb       (mseccfg_q.rlb),
      .cfg       (cfg_q[g]),
      .addr      (addr_q[g]),
      .cfg_rdata (cfg_rdata[g]),
      .addr_rdata(addr_rdata[g]),
      .ignored   (entry_ignored[g])
    );

    assign entry_lock[g]     = cfg_q[g].lock;
    assign csr_pmp_cfg_o[g]  = cfg_q[g];
    assign csr_pmp_addr_o[g] = {addr_q[g], 2'b00};
  end

  // RLB may only change while it is already set or no region carries L.
  always_comb begin
    mseccfg_we   = csr_we_i && (csr_addr_i == CSR_MSECCFG);
    rlb_writable = mseccfg_q.rlb | ~(|entry_lock);
    rlb_ignored  = mseccfg_we & ~rlb_writable & (csr_wdata_i[2] != mseccfg_q.rlb);
  end

  // mseccfg register: MML and MMWP only ever get set until the next reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mseccfg_q <= '0;
    end else if (mseccfg_we) begin
      mseccfg_q.mml  <= mseccfg_q.mml | csr_wdata_i[0];
      mseccfg_q.mmwp <= mseccfg_q.mmwp | csr_wdata_i[1];
      if (rlb_writable) begin
        mseccfg_q.rlb <= csr_wdata_i[2];
      end
    end
  end

  // One-cycle flag after a write that had any field suppressed.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      csr_wr_ignored_o <= 1'b0;
    end else begin
      csr_wr_ignored_o <= (|entry_ignored) | rlb_ignored;
    end
  end

  // Combinational read mux; unimplemented entries and misses read as zero.
  always_comb begin
    csr_rdata_o = '0;
    if (csr_addr_i == CSR_MSECCFG) begin
      csr_rdata_o = {29'b0, mseccfg_q.rlb, mseccfg_q.mmwp, mseccfg_q.mml};
    end
    for (int i = 0; i < PMPNumRegions; i++) begin
      if (csr_addr_i == (CSR_PMPCFG0 + 12'(i / 4))) begin
        csr_rdata_o[8*(i%4)+:8] = cfg_rdata[i];
      end
      if (csr_addr_i == (CSR_PMPADDR0 + 12'(i))) begin
        csr_rdata_o = addr_rdata[i];
      end
    end
  end

  assign csr_pmp_mseccfg_o = mseccfg_q;

endmodule

// File: tb/tb_ibex_pmp_csr.sv
// Scoreboard bench for ibex_pmp_csr: a G=0 and a G=2 instance share all inputs.
module tb_ibex_pmp_csr;
  import ibex_pmp_csr_pkg::*;

  localparam int unsigned NumRegions = 4;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         csr_we_i = 1'b0;
  logic [11:0]  csr_addr_i = '0;
  logic [31:0]  csr_wdata_i = '0;

  logic [31:0]  rdata;
  logic         hit;
  logic         wr_ignored;
  pmp_cfg_t     cfg_out  [NumRegions];
  logic [33:0]  addr_out [NumRegions];
  pmp_mseccfg_t mseccfg_out;

  logic [31:0]  rdata_g2;
  logic         hit_g2;
  logic         wr_ignored_g2;
  pmp_cfg_t     cfg_out_g2  [NumRegions];
  logic [33:0]  addr_out_g2 [NumRegions];
  pmp_mseccfg_t mseccfg_out_g2;

  typedef struct {
    string       tag;
    bit          use_g2;
    logic [11:0] addr;
    logic [31:0] exp;
  } read_exp_t;

  read_exp_t scoreboard[$];
  int        checks_run = 0;
  int        checks_passed = 0;

  ibex_pmp_csr #(.PMPGranularity(0), .PMPNumRegions(NumRegions)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .csr_we_i         (csr_we_i),
    .csr_addr_i       (csr_addr_i),
    .csr_wdata_i      (csr_wdata_i),
    .csr_rdata_o      (rdata),
    .csr_hit_o        (hit),
    .csr_wr_ignored_o (wr_ignored),
    .csr_pmp_cfg_o    (cfg_out),
    .csr_pmp_addr_o   (addr_out),
    .csr_pmp_mseccfg_o(mseccfg_out)
  );

  ibex_pmp_csr #(.PMPGranularity(2), .PMPNumRegions(NumRegions)) dut_g2 (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .csr_we_i         (csr_we_i),
    .csr_addr_i       (csr_addr_i),
    .csr_wdata_i      (csr_wdata_i),
    .csr_rdata_o      (rdata_g2),
    .csr_hit_o        (hit_g2),
    .csr_wr_ignored_o (wr_ignored_g2),
    .csr_pmp_cfg_o    (cfg_out_g2),
    .csr_pmp_addr_o   (addr_out_g2),
    .csr_pmp_mseccfg_o(mseccfg_out_g2)
  );

  // Free-running clock.
  always #5 clk_i = ~clk_i;

  // Guard against a stalled run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks_run++;
    if (observed === expected) checks_passed++;
    else $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  // One-cycle write driven from a negedge; returns at the next negedge.
  task automatic applyStimulus(input logic [11:0] addr, input logic [31:0] data);
    @(negedge clk_i);
    csr_we_i    = 1'b1;
    csr_addr_i  = addr;
    csr_wdata_i = data;
    @(negedge clk_i);
    csr_we_i    = 1'b0;
  endtask

  task automatic expectRead(input string tag, input bit use_g2, input logic [11:0] addr,
                            input logic [31:0] exp);
    read_exp_t e;
    e.tag = tag;
    e.use_g2 = use_g2;
    e.addr = addr;
    e.exp = exp;
    scoreboard.push_back(e);
  endtask

  task automatic drainReads();
    read_exp_t e;
    while (scoreboard.size() > 0) begin
      e = scoreboard.pop_front();
      csr_addr_i = e.addr;
      #1;
      checkOutput(e.tag, 64'(e.use_g2 ? rdata_g2 : rdata), 64'(e.exp));
    end
  endtask

  task automatic doReset();
    csr_we_i = 1'b0;
    rst_ni   = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni   = 1'b1;
  endtask

  initial begin
    doReset();

    // Reset state.
    checkOutput("rst_mode0", 64'(cfg_out[0].mode), 64'(PMP_MODE_OFF));
    checkOutput("rst_mseccfg", 64'(mseccfg_out), 64'd0);
    checkOutput("rst_ignored", 64'(wr_ignored), 64'd0);
    expectRead("rst_cfg0", 0, 12'h3A0, 32'h0);
    expectRead("rst_addr0", 0, 12'h3B0, 32'h0);
    expectRead("rst_mseccfg_rd", 0, 12'h747, 32'h0);
    drainReads();

    // Locked TOR entry guards its own and the previous address.
    applyStimulus(12'h3B1, 32'h0000_1000);
    applyStimulus(12'h3A0, 32'h0000_8D00);
    checkOutput("tor_ign_clean", 64'(wr_ignored), 64'd0);
    checkOutput("tor_addr1_out", 64'(addr_out[1]), 64'h4000);
    checkOutput("tor_lock1", 64'(cfg_out[1].lock), 64'd1);
    applyStimulus(12'h3B0, 32'h0000_AAAA);
    checkOutput("tor_ign_addr0", 64'(wr_ignored), 64'd1);
    applyStimulus(12'h3B1, 32'h0000_2222);
    checkOutput("tor_ign_addr1", 64'(wr_ignored), 64'd1);
    applyStimulus(12'h3A0, 32'h0000_0001);
    checkOutput("tor_ign_cfgbyte", 64'(wr_ignored), 64'd1);
    @(negedge clk_i);
    checkOutput("tor_ign_pulse_end", 64'(wr_ignored), 64'd0);
    expectRead("tor_addr0_rd", 0, 12'h3B0, 32'h0);
    expectRead("tor_addr1_rd", 0, 12'h3B1, 32'h0000_1000);
    expectRead("tor_cfg_rd", 0, 12'h3A0, 32'h0000_8D01);
    drainReads();

    // W without R is cleared unless MML is set.
    doReset();
    applyStimulus(12'h3A0, 32'h0000_0002);
    expectRead("warl_w_only", 0, 12'h3A0, 32'h0);
    drainReads();
    applyStimulus(12'h747, 32'h1);
    applyStimulus(12'h3A0, 32'h0000_0002);
    expectRead("warl_w_only_mml", 0, 12'h3A0, 32'h0000_0002);
    expectRead("mml_set", 0, 12'h747, 32'h1);
    drainReads();

    // RLB blocked by a lock; MML/MMWP sticky; MML blocks locked executable rule.
    doReset();
    applyStimulus(12'h3A0, 32'h0000_0081);
    applyStimulus(12'h747, 32'h4);
    expectRead("rlb_blocked", 0, 12'h747, 32'h0);
    drainReads();
    applyStimulus(12'h747, 32'h3);
    applyStimulus(12'h747, 32'h0);
    expectRead("mseccfg_sticky", 0, 12'h747, 32'h3);
    drainReads();
    applyStimulus(12'h3A0, 32'h0000_8581);
    checkOutput("mml_lock_x_ign", 64'(wr_ignored), 64'd1);
    expectRead("mml_lock_x_rd", 0, 12'h3A0, 32'h0000_0081);
    drainReads();

    // RLB bypasses locks.
    doReset();
    applyStimulus(12'h747, 32'h4);
    applyStimulus(12'h3A0, 32'h0000_008C);
    applyStimulus(12'h3A0, 32'h0000_0000);
    checkOutput("rlb_bypass_ign", 64'(wr_ignored), 64'd0);
    expectRead("rlb_bypass_cfg", 0, 12'h3A0, 32'h0);
    expectRead("rlb_set", 0, 12'h747, 32'h4);
    drainReads();

    // Granularity-dependent readback and NA4 legalisation.
    doReset();
    applyStimulus(12'h3A0, 32'h0000_0019);
    applyStimulus(12'h3B0, 32'h0000_00FF);
    expectRead("g2_napot", 1, 12'h3B0, 32'h0000_00FF);
    expectRead("g0_napot", 0, 12'h3B0, 32'h0000_00FF);
    drainReads();
    applyStimulus(12'h3A0, 32'h0000_0009);
    expectRead("g2_tor", 1, 12'h3B0, 32'h0000_00FC);
    expectRead("g0_tor", 0, 12'h3B0, 32'h0000_00FF);
    drainReads();
    checkOutput("g2_addr_out", 64'(addr_out_g2[0]), 64'h3FC);
    applyStimulus(12'h3A0, 32'h0000_0011);
    expectRead("g2_na4_off", 1, 12'h3A0, 32'h0000_0001);
    expectRead("g0_na4_kept", 0, 12'h3A0, 32'h0000_0011);
    expectRead("g2_off_addr", 1, 12'h3B0, 32'h0000_00FC);
    drainReads();

    // Unimplemented entries, mseccfgh and misses.
    doReset();
    csr_addr_i = 12'h3B5;
    #1 checkOutput("hit_unimpl", 64'(hit), 64'd1);
    csr_addr_i = 12'h3A4;
    #1 checkOutput("hit_3a4", 64'(hit), 64'd0);
    csr_addr_i = 12'h757;
    #1 checkOutput("hit_mseccfgh", 64'(hit), 64'd1);
    csr_addr_i = 12'h123;
    #1 checkOutput("hit_miss", 64'(hit), 64'd0);
    applyStimulus(12'h3B5, 32'hFFFF_FFFF);
    applyStimulus(12'h3A1, 32'hFFFF_FFFF);
    applyStimulus(12'h757, 32'h0000_0007);
    applyStimulus(12'h123, 32'hFFFF_FFFF);
    expectRead("unimpl_addr", 0, 12'h3B5, 32'h0);
    expectRead("unimpl_cfg", 0, 12'h3A1, 32'h0);
    expectRead("mseccfgh_rd", 0, 12'h757, 32'h0);
    expectRead("mseccfg_untouched", 0, 12'h747, 32'h0);
    expectRead("miss_rd", 0, 12'h123, 32'h0);
    expectRead("miss_no_alias", 0, 12'h3B0, 32'h0);
    drainReads();

    // Same-cycle read returns the old value.
    @(negedge clk_i);
    csr_we_i = 1'b1;
    csr_addr_i = 12'h3B2;
    csr_wdata_i = 32'h0000_1234;
    #1 checkOutput("same_cycle_old", 64'(rdata), 64'h0);
    @(negedge clk_i);
    csr_we_i = 1'b0;
    #1 checkOutput("next_cycle_new", 64'(rdata), 64'h1234);

    // Async reset during a write drops the write.
    applyStimulus(12'h3B0, 32'h0000_0077);
    checkOutput("pre_rst_addr", 64'(addr_out[0]), 64'h1DC);
    @(negedge clk_i);
    csr_we_i = 1'b1;
    csr_addr_i = 12'h3B0;
    csr_wdata_i = 32'h0000_0055;
    #2 rst_ni = 1'b0;
    @(posedge clk_i);
    #1 checkOutput("rst_mid_write", 64'(addr_out[0]), 64'h0);
    csr_we_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    expectRead("rst_mid_write_rd", 0, 12'h3B0, 32'h0);
    expectRead("rst_mid_addr2", 0, 12'h3B2, 32'h0);
    drainReads();

    $display("%0d/%0d checks passed", checks_passed, checks_run);
    $finish;
  end

endmodule

// File: doc/ibex_pmp_csr.md
Name: ibex_pmp_csr

Overview:
- Architectural PMP CSR storage: the writer side of the PMP checker's configuration interface.
- Decodes CSR writes to pmpcfg0-3, pmpaddr0-15 and mseccfg/mseccfgh.
- Applies lock, TOR-lock, WARL and Smepmp (MML/MMWP/RLB) write rules.
- Registers the resulting per-region cfg/addr and mseccfg, driven straight into the PMP checker inputs; also provides CSR read data.

Parameters:
- PMPGranularity, 0, NAPOT granularity G (0 = 4 byte, 1 = 8 byte, ...).
- PMPNumRegions, 4, implemented regions (1-16); unimplemented entries read 0 and ignore writes.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- csr_we_i  in  1  CSR write strobe (single-cycle, no backpressure)
- csr_addr_i  in  12  CSR address (read and write)
- csr_wdata_i  in  32  write data
- csr_rdata_o  out  32  combinational read data for csr_addr_i
- csr_hit_o  out  1  csr_addr_i is a PMP/mseccfg address
- csr_wr_ignored_o  out  1  registered pulse: previous-cycle write hit had ≥1 field suppressed by lock rules
- csr_pmp_cfg_o  out  pmp_cfg_t[PMPNumRegions]  per-region cfg to checker
- csr_pmp_addr_o  out  34[PMPNumRegions]  byte address {pmpaddr,2'b00} to checker
- csr_pmp_mseccfg_o  out  pmp_mseccfg_t  mml/mmwp/rlb to checker

Behaviour:
- Reset: all cfg fields 0 (mode OFF), all addr 0, mseccfg 0, csr_wr_ignored_o 0.
- Write latency: a write in cycle N is visible on outputs and csr_rdata_o in cycle N+1. A same-cycle read returns the old value.
- Address map:
  - pmpcfgK at 0x3A0+K; byte j holds entry 4K+j: {L[7], 00, A[4:3], X[2], W[1], R[0]}.
  - pmpaddrI at 0x3B0+I, bits [31:0] = addr[33:2].
  - mseccfg at 0x747: {RLB[2], MMWP[1], MML[0]}.
  - mseccfgh at 0x757 reads 0; writes are dropped.
- Per-entry lock: locked = L & ~RLB.
  - A pmpcfg byte write to a locked entry is ignored. The other bytes in the same CSR still apply.
  - pmpaddrI write is ignored if entry I is locked, or if entry I+1 is locked and in TOR mode.
  - Lock checks always use the stored (pre-write) values, never same-write data.
- cfg WARL:
  - R=0,W=1 with MML=0 is stored as W=0.
  - NA4 with G≥1 is stored as OFF.
- MML=1 and RLB=0: a byte write setting L=1 with (X=1 or (R=0 & W=1)) is ignored.
- mseccfg:
  - MML and MMWP are sticky-set: writing 0 has no effect until reset.
  - RLB is writable only when RLB=1 already or no stored entry has L=1; otherwise the RLB bit write is ignored. MML/MMWP in the same write still apply.
- pmpaddr readback:
  - NAPOT with G≥2: bits [G-2:0] read 1.
  - OFF/TOR with G≥1: bits [G-1:0] read 0.
  - Stored bits are unchanged in both cases.
- Reads:
  - Unimplemented regions read 0.
  - Non-hit addresses give csr_hit_o=0 and rdata 0.
  - A write to a non-hit address is dropped.
- csr_wr_ignored_o asserts for one cycle after any suppressed field in a hit write.
- Reset mid-write: async reset wins; the pending write is lost.

Decomposition:
- ibex_pkg additions:
  - CSR address constants: CSR_PMPCFG0..3, CSR_PMPADDR0..15, CSR_MSECCFG, CSR_MSECCFGH.
  - pmp_cfg_t and pmp_mseccfg_t (existing).
  - PMP_CFG_W=8.
- One sub-module, ibex_pmp_csr_entry:
  - Holds one region's cfg+addr flops.
  - Computes that entry's write-enable and WARL-legalised next value.
  - Inputs: neighbour lock/mode, mseccfg.
  - Instantiated PMPNumRegions times.

Test Plan:
- Reset, then read 0x3A0, 0x3B0, 0x747 -> all read 0; outputs mode OFF, mseccfg 0.
- Write 0x3B1=0x0000_1000, then 0x3A0=0x0000_8D00 (entry1: L, TOR, X, R) -> csr_pmp_addr_o[1]=0x4000; then writes to 0x3B0 and 0x3B1 are ignored, csr_wr_ignored_o pulses, and readbacks are unchanged.
- 0x3A0=0x0000_0002 (R=0,W=1, MML=0) -> entry0 reads 0x00. Set mseccfg=0x1 and rewrite 0x3A0=0x0000_0002 -> entry0 reads 0x02.
- Lock entry0 (0x3A0=0x81), then write mseccfg=0x4 -> RLB stays 0. Write mseccfg=0x3, then 0x0 -> reads 0x3 (sticky).
- From reset: mseccfg=0x4, 0x3A0=0x8C, then 0x3A0=0x00 -> accepted (RLB bypass); read 0x00.
- G=2, 0x3B0=0x0000_00FF with entry0 NAPOT -> reads 0x0000_00FF; switch to TOR -> reads 0x0000_00FC.
